// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state encodings and sizing constants for the SPI arbiter.
package spi_arb_pkg;
  localparam int MAX_REQ = 4;
  localparam int IDX_W = 2;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OWN   = 3'd1,
    ST_START = 3'd2,
    ST_XFER  = 3'd3,
    ST_GUARD = 3'd4
  } state_t;
endpackage

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: requester-side byte bus between register decode and the SPI arbiter.
interface spi_arbiter_if #(parameter int NREQ = 2);
  import spi_arb_pkg::*;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] wr;
  logic [BYTE_W*NREQ-1:0] wdata;
  logic [NREQ-1:0] rdy;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rvalid;
  logic [BYTE_W-1:0] rdata;
  modport master (output req, wr, wdata, input rdy, gnt, rvalid, rdata);
  modport slave (input req, wr, wdata, output rdy, gnt, rvalid, rdata);
endinterface

// File: rtl/spi_arbiter_rr_picker.sv
// rr_picker: combinational round-robin first-one finder starting at ptr, with wrap.
module rr_picker
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);
  logic [MAX_REQ-1:0] req_w;
  logic [IDX_W:0] sum;
  logic [IDX_W-1:0] j;
  logic found;
  assign req_w = MAX_REQ'(req);
  always_comb begin
    idx = '0;
    found = 1'b0;
    sum = '0;
    j = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      j = (sum >= (IDX_W+1)'(NREQ)) ? IDX_W'(sum - (IDX_W+1)'(NREQ)) : IDX_W'(sum);
      idx = (!found && req_w[j]) ? j : idx;
      found = found | req_w[j];
    end
  end
  assign gnt = found ? (NREQ'(1) << idx) : '0;
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: burst-granting round-robin arbiter sharing one SPI byte engine.
// Optional idle-ownership timeout with forced release: define SPIARB_TIMEOUT_EN.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int GUARD = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              cclk,
  input  logic              reset,
  spi_arbiter_if.slave      bus,
  output logic [NREQ-1:0]   ss_n,
  output logic              eng_start,
  output logic [BYTE_W-1:0] eng_txd,
  input  logic              eng_busy,
  input  logic [BYTE_W-1:0] eng_rxd,
  output logic              tout
);
  // The IDLE arbitration cycle keeps ss_n high too, so it counts as the last guard cycle.
  localparam int GL = (GUARD > 1) ? GUARD - 1 : 1;
  localparam int CW = $clog2(TIMEOUT + GUARD + 4);
  state_t state, state_n;
  logic [IDX_W-1:0] owner, ptr, pick_idx;
  logic [NREQ-1:0] owner_oh, pick_oh;
  logic [CW-1:0] cnt;
  logic [BYTE_W-1:0] wsel;
  logic req_own, wr_own, tmo, busy_fell;
  rr_picker #(.NREQ(NREQ)) u_pick (
    .req(bus.req),
    .ptr(ptr),
    .gnt(pick_oh),
    .idx(pick_idx)
  );
  assign req_own = |(bus.req & owner_oh);
  assign wr_own = |(bus.wr & owner_oh);
  assign busy_fell = (state == ST_XFER) && !eng_busy;
  assign bus.gnt = (state == ST_OWN || state == ST_START || state == ST_XFER) ? owner_oh : '0;
  assign bus.rdy = (state == ST_OWN) ? owner_oh : '0;
  assign ss_n = ~bus.gnt;
  always_comb begin
    wsel = '0;
    for (int k = 0; k < NREQ; k++)
      wsel = (owner == IDX_W'(k)) ? bus.wdata[k*BYTE_W +: BYTE_W] : wsel;
  end
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  state_n = |bus.req ? ST_OWN : ST_IDLE;
      ST_OWN:   state_n = wr_own ? ST_START : (!req_own || tmo) ? ST_GUARD : ST_OWN;
      ST_START: state_n = eng_busy ? ST_XFER : (cnt == CW'(2)) ? ST_GUARD : ST_START;
      ST_XFER:  state_n = eng_busy ? ST_XFER : req_own ? ST_OWN : ST_GUARD;
      ST_GUARD: state_n = (cnt == CW'(GL - 1)) ? ST_IDLE : ST_GUARD;
      default:  state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge cclk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      owner <= '0;
      owner_oh <= '0;
      ptr <= '0;
      cnt <= '0;
      eng_start <= 1'b0;
      eng_txd <= '0;
      bus.rvalid <= '0;
      bus.rdata <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state) ? '0 : cnt + CW'(1);
      eng_start <= (state == ST_OWN) && wr_own;
      bus.rvalid <= busy_fell ? owner_oh : '0;
      if (state == ST_IDLE) begin
        owner <= pick_idx;
        owner_oh <= pick_oh;
      end
      if (state == ST_OWN && wr_own) eng_txd <= wsel;
      if (busy_fell) bus.rdata <= eng_rxd;
      if (state == ST_GUARD) ptr <= (owner == IDX_W'(NREQ - 1)) ? '0 : owner + IDX_W'(1);
    end
  end
`ifdef SPIARB_TIMEOUT_EN
  assign tmo = (state == ST_OWN) && !wr_own && req_own && (cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge cclk or posedge reset) begin
    if (reset) tout <= 1'b0;
    else tout <= tout | tmo;
  end
`else
  assign tmo = 1'b0;
  assign tout = 1'b0;
`endif
endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares one 8-bit SPI byte engine (mode 0 shift FSM, start/busy handshake) between NREQ requesters, e.g. CPU-side register port and a flash loader.
- Grants whole bursts (requester holds req for multiple bytes), drives one active-low slave select per requester, and returns received bytes.
- Round-robin fairness between bursts; guard cycles on SS release.
- Sits between the peripheral register decode and the SPI shift engine in SYSTEM.

Parameters:
- NREQ, 2, number of requesters (2..4).
- GUARD, 2, cclk cycles ss_n held high after a burst before the next grant (>=1).
- TIMEOUT, 1024, idle cycles before forced release (only with SPIARB_TIMEOUT_EN).

Ports:
- cclk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- req  in  NREQ  burst request per requester; held high for the whole burst.
- wr  in  NREQ  byte-write strobe per requester; accepted only when rdy[i]=1.
- wdata  in  8*NREQ  flattened tx bytes; requester i uses bits [8i+7:8i].
- rdy  out  NREQ  requester i granted and arbiter able to accept a byte.
- gnt  out  NREQ  one-hot grant, or zero.
- rvalid  out  NREQ  1-cycle pulse when requester i's byte completes.
- rdata  out  8  received byte; valid while any rvalid is high, held until the next byte.
- ss_n  out  NREQ  active-low slave selects; at most one low.
- eng_start  out  1  1-cycle start pulse to the engine.
- eng_txd  out  8  byte to the engine; stable from eng_start until busy falls.
- eng_busy  in  1  engine busy; rises the cycle after eng_start.
- eng_rxd  in  8  engine received byte; valid when busy falls.
- tout  out  1  sticky forced-release flag; cleared by reset only.

Behaviour:
- Reset values: gnt=0, rdy=0, rvalid=0, rdata=0, ss_n=all 1, eng_start=0, eng_txd=0, tout=0, rr pointer=0, state IDLE.
- FSM states: IDLE, OWN, START, XFER, GUARD.
- IDLE -> OWN:
  - Any req seen: pick the first set req[i] scanning from the rr pointer upward, with wrap.
  - Next edge: gnt[i]=1 and ss_n[i]=0.
- OWN:
  - rdy[i]=1.
  - wr[i]=1 latches wdata slice into eng_txd, pulses eng_start next cycle, and goes to START.
  - req[i]=0 with no wr goes to GUARD.
  - wr and req falling in the same cycle: the byte is accepted and the release happens after it completes.
- START: rdy=0; waits for eng_busy=1, then XFER. If busy never rises within 2 cycles, treat as an engine fault: go to GUARD.
- XFER:
  - On eng_busy falling: rdata<=eng_rxd and rvalid[i] pulses for 1 cycle.
  - Return to OWN if req[i] is still 1, else GUARD.
  - Byte latency: wr to rvalid = 3 + engine time.
- GUARD:
  - gnt=0, ss_n all high.
  - Counts GUARD cycles, sets rr pointer = i+1 mod NREQ, then IDLE.
- Other inputs:
  - wr from a non-granted requester, or while rdy=0, is ignored (dropped, no side effect).
  - req from a non-granted requester changes nothing until the next IDLE.
- Simultaneous requests are resolved by rr order only; no priority levels.
- Reset mid-burst: immediate return to reset values; ss_n deasserts asynchronously. The engine is reset by the same reset.

Optional Feature:
- SPIARB_TIMEOUT_EN defined:
  - In OWN, a counter counts cycles without wr[i].
  - Reaching TIMEOUT forces GUARD and sets tout=1.
  - The counter clears on each accepted wr.
- Undefined: no counter; a requester may hold ownership indefinitely; tout tied to 0.

Decomposition:
- Shared package spi_arb_pkg: state encodings (IDLE=0..GUARD=4), NREQ max constant, byte-width constant.
- One natural sub-module: rr_picker (combinational round-robin first-one finder, inputs req and pointer, outputs one-hot and index).
- The FSM stays in spi_arbiter.

Test Plan:
- Single burst:
  - Stimulus: req[0]=1, write bytes 0x9F,0x00,0x00; engine model echoes ~tx.
  - Response: ss_n=2'b10 throughout, rvalid[0] three times with rdata 0x60,0xFF,0xFF, then ss_n=2'b11 for exactly 2 cycles before any new grant.
- Contention:
  - Stimulus: req=2'b11 from reset, each requester does a 1-byte burst and keeps requesting.
  - Response: grants alternate 0,1,0,1; ss_n never 2'b00.
- Foreign write:
  - Stimulus: wr[1]=1 with 0xAA while requester 0 is granted.
  - Response: no eng_start and no rvalid[1].
- Release with last byte:
  - Stimulus: wr[0] and req[0] fall in the same cycle.
  - Response: byte is still transferred and rvalid[0] pulses, then GUARD.
- Reset mid-XFER:
  - Stimulus: assert reset while eng_busy=1.
  - Response: ss_n=all 1, gnt=0, rvalid=0 within the same cycle.
- With SPIARB_TIMEOUT_EN, TIMEOUT=16:
  - Stimulus: hold req[0] with no wr.
  - Response: forced release after 16 cycles, tout=1, requester 1 then granted.
